// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte enables, read-valid strobe and range check.
// Define RAM_SP_CLEAR_EN to build the post-reset clear sweep (busy is high while it runs).
module ram_sp_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                enable,
    input  logic                r_w,
    input  logic [ADDR_W-1:0]   add,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] wbe,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                busy,
    output logic                err
);

    localparam int unsigned     NBYTES    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_cnt;

    assign accept   = ce & enable & ~busy;
    assign in_range = {1'b0, add} < DEPTH_EXT;

`ifdef RAM_SP_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t state;

    // Clear sweep: one word per ce edge, stops on the last implemented address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (ce) begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we = ce & (state == ST_CLEAR);
`else
    assign busy    = 1'b0;
    assign clr_cnt = '0;
    assign clr_we  = 1'b0;
`endif

    // Storage: sweep clear has priority; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (accept && r_w && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wbe[i]) begin
                    mem[add][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Read port and status strobes; strobes self-clear whenever no request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_valid <= accept & ~r_w;
            err        <= accept & ~in_range;
            if (accept && !r_w) begin
                data_out <= in_range ? mem[add] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench for ram_sp_param: a 64-word and a 40-word instance share stimulus.
// Expected responses are queued at issue time and popped by a negedge monitor.
module tb_ram_sp_param;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [15:0] data;
    } exp_t;

`ifdef RAM_SP_CLEAR_EN
    localparam logic        BUSY_RST = 1'b1;
    localparam logic [15:0] BEEF_EXP = 16'h0000;
`else
    localparam logic        BUSY_RST = 1'b0;
    localparam logic [15:0] BEEF_EXP = 16'hBEEF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        enable = 1'b0;
    logic        r_w = 1'b0;
    logic        in_sweep = 1'b0;
    logic [5:0]  add = '0;
    logic [15:0] data_in = '0;
    logic [1:0]  wbe = '0;
    logic        en40;

    logic [15:0] d64, d40;
    logic        dv64, dv40, busy64, busy40, err64, err40;

    int checks = 0;
    int errors = 0;
    exp_t q64[$];
    exp_t q40[$];

    assign en40 = enable & ~in_sweep;

    always #5 clk = ~clk;

    ram_sp_param u64 (
        .clk(clk), .rst(rst), .ce(ce), .enable(enable), .r_w(r_w), .add(add),
        .data_in(data_in), .wbe(wbe), .data_out(d64), .data_valid(dv64),
        .busy(busy64), .err(err64)
    );

    ram_sp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(40)) u40 (
        .clk(clk), .rst(rst), .ce(ce), .enable(en40), .r_w(r_w), .add(add),
        .data_in(data_in), .wbe(wbe), .data_out(d40), .data_valid(dv40),
        .busy(busy40), .err(err40)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: any strobe from a DUT consumes the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dv64 || err64) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u64_unexpected: got dv=%0b err=%0b data=%h expected no response", dv64, err64, d64);
                end else begin
                    e = q64.pop_front();
                    check("u64_valid", 32'(dv64), 32'(e.valid));
                    check("u64_err", 32'(err64), 32'(e.err));
                    if (e.valid) check("u64_data", 32'(d64), 32'(e.data));
                end
            end
            if (dv40 || err40) begin
                if (q40.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u40_unexpected: got dv=%0b err=%0b data=%h expected no response", dv40, err40, d40);
                end else begin
                    e = q40.pop_front();
                    check("u40_valid", 32'(dv40), 32'(e.valid));
                    check("u40_err", 32'(err40), 32'(e.err));
                    if (e.valid) check("u40_data", 32'(d40), 32'(e.data));
                end
            end
        end
    end

    task automatic op(input logic we, input logic [5:0] a, input logic [15:0] d, input logic [1:0] be,
                      input exp_t e64, input exp_t e40);
        @(negedge clk);
        ce = 1'b1; enable = 1'b1; r_w = we; add = a; data_in = d; wbe = be;
        if (e64.valid || e64.err) q64.push_back(e64);
        if (e40.valid || e40.err) q40.push_back(e40);
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
        op(1'b1, a, d, be, exp_t'{1'b0, 1'b0, 16'h0}, exp_t'{1'b0, a >= 6'd40, 16'h0});
    endtask

    task automatic rd(input logic [5:0] a, input logic [15:0] x64, input logic [15:0] x40);
        op(1'b0, a, 16'h0, 2'b00, exp_t'{1'b1, 1'b0, x64}, exp_t'{1'b1, a >= 6'd40, x40});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d64"}, 32'(d64), 32'h0);
        check({tag, "_dv64"}, 32'(dv64), 32'h0);
        check({tag, "_err64"}, 32'(err64), 32'h0);
        check({tag, "_busy64"}, 32'(busy64), 32'(BUSY_RST));
        check({tag, "_d40"}, 32'(d40), 32'h0);
        check({tag, "_busy40"}, 32'(busy40), 32'(BUSY_RST));
    endtask

`ifdef RAM_SP_CLEAR_EN
    // Counts ce=1 edges until each instance drops busy, then lets one read of address 5 through
    task automatic sweep_check(input int skip_at, input int skip_len);
        int n = 0;
        int g = 0;
        int n64 = 0;
        int n40 = 0;
        in_sweep = 1'b1; enable = 1'b1; r_w = 1'b0; add = 6'd5;
        for (int c = 0; c < 400; c++) begin
            if (n == skip_at && g < skip_len) begin
                ce = 1'b0;
                g++;
            end else begin
                ce = 1'b1;
            end
            @(posedge clk);
            if (ce) n++;
            #1;
            if (!busy64 && n64 == 0) n64 = n;
            if (!busy40 && n40 == 0) n40 = n;
            if (n64 != 0 && n40 != 0) break;
        end
        ce = 1'b1;
        check("sweep_len_64", 32'(n64), 32'd64);
        check("sweep_len_40", 32'(n40), 32'd40);
        q64.push_back(exp_t'{1'b1, 1'b0, 16'h0000});
        q40.push_back(exp_t'{1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        in_sweep = 1'b0;
        @(negedge clk);
        enable = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

`ifdef RAM_SP_CLEAR_EN
        sweep_check(20, 10);
        // Restart the sweep at edge 30 of a fresh sweep
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_sweep = 1'b1; enable = 1'b1; ce = 1'b1; r_w = 1'b0; add = 6'd5;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midsweep_busy64", 32'(busy64), 32'h1);
        rst = 1'b0;
        sweep_check(-1, 0);
        rd(6'd0, 16'h0000, 16'h0000);
        rd(6'd1, 16'h0000, 16'h0000);
        rd(6'd2, 16'h0000, 16'h0000);
`endif

        // Byte enables
        wr(6'd3, 16'hABCD, 2'b11);
        wr(6'd3, 16'h12FF, 2'b01);
        rd(6'd3, 16'hABFF, 16'hABFF);

        // Range boundaries (40 words vs 64 words)
        wr(6'd5, 16'h5555, 2'b11);
        wr(6'd45, 16'h1111, 2'b11);
        rd(6'd45, 16'h1111, 16'h0000);
        rd(6'd5, 16'h5555, 16'h5555);
        wr(6'd39, 16'h3939, 2'b11);
        wr(6'd40, 16'h4040, 2'b11);
        wr(6'd63, 16'h7E7E, 2'b11);
        rd(6'd39, 16'h3939, 16'h3939);
        rd(6'd40, 16'h4040, 16'h0000);
        rd(6'd63, 16'h7E7E, 16'h0000);
        rd(6'd3, 16'hABFF, 16'hABFF);
        rd(6'd5, 16'h5555, 16'h5555);

        // Empty byte mask is a no-op, upper byte alone
        wr(6'd3, 16'h0000, 2'b00);
        wr(6'd3, 16'h7700, 2'b10);
        rd(6'd3, 16'h77FF, 16'h77FF);

        // ce=0 blocks writes and reads
        @(negedge clk);
        ce = 1'b0; enable = 1'b1; r_w = 1'b1; add = 6'd3; data_in = 16'h0000; wbe = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                r_w = 1'b0;
                add = 6'd5;
            end
            check("ce0_dv64", 32'(dv64), 32'h0);
            check("ce0_dv40", 32'(dv40), 32'h0);
            check("ce0_hold64", 32'(d64), 32'h77FF);
            check("ce0_hold40", 32'(d40), 32'h77FF);
        end
        rd(6'd3, 16'h77FF, 16'h77FF);

        // Reset right after a read is accepted aborts its data_valid
        wr(6'd7, 16'hBEEF, 2'b11);
        op(1'b0, 6'd5, 16'h0, 2'b00, exp_t'{1'b0, 1'b0, 16'h0}, exp_t'{1'b0, 1'b0, 16'h0});
        @(posedge clk);
        #2 rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
`ifdef RAM_SP_CLEAR_EN
        sweep_check(-1, 0);
`else
        @(negedge clk);
        check("post_reset_busy64", 32'(busy64), 32'h0);
        check("post_reset_busy40", 32'(busy40), 32'h0);
`endif
        rd(6'd7, BEEF_EXP, BEEF_EXP);

        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("q64_drained", 32'(q64.size()), 32'h0);
        check("q40_drained", 32'(q40.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
